// File: rtl/wb_ic_pkg.sv
// Shared definitions for the Wishbone decode interconnect: default slave
// map, FSM state encoding and error-cause encoding.
// Optional feature macro used by the top: WB_IC_ERR_CAPTURE_EN.
package wb_ic_pkg;

  localparam int NUM_SLAVES_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ERR    = 2'd2
  } wb_ic_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_UNMAPPED = 2'b01,
    ERR_SLAVE    = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } err_cause_t;

  // Slave base addresses; indices beyond the default map never match.
  function automatic logic [31:0] slave_base(input int k);
    case (k)
      0:       slave_base = 32'h0000_0000;
      1:       slave_base = 32'h2000_0000;
      2:       slave_base = 32'h2000_1000;
      3:       slave_base = 32'h2000_2000;
      default: slave_base = 32'hFFFF_FFFF;
    endcase
  endfunction

  // Slave address masks; unmapped indices compare every bit against an
  // all-ones base, and the top nibble of that base is never produced by
  // any real slave window in the default map.
  function automatic logic [31:0] slave_mask(input int k);
    case (k)
      0:       slave_mask = 32'hF000_0000;
      1:       slave_mask = 32'hFFFF_F000;
      2:       slave_mask = 32'hFFFF_F000;
      3:       slave_mask = 32'hFFFF_F000;
      default: slave_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

  // Width of a slave index; at least one bit even for a single slave.
  function automatic int idx_w(input int n);
    idx_w = (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_ic_addr_decoder.sv
// Combinational address decoder: matches the address against the slave
// map and reports a hit plus the lowest matching slave index.
module wb_ic_addr_decoder
  import wb_ic_pkg::*;
#(
  parameter int NUM_SLAVES = NUM_SLAVES_DEF,
  parameter int IDX_W      = idx_w(NUM_SLAVES)
) (
  input  logic [31:0]      adr_i,
  output logic             hit_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scan from the highest index down so the lowest matching index wins.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if ((adr_i & slave_mask(k)) == slave_base(k)) begin
        hit_o = 1'b1;
        idx_o = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/wb_decode_interconnect.sv
// Single-master, multi-slave Wishbone interconnect. Latches the master
// request, routes cyc/stb to one decoded slave, passes ack/err back, and
// registers read data one cycle after ack. Unmapped addresses and slaves
// that stay silent past TIMEOUT_CYCLES produce a bus error.
// Optional feature macro: WB_IC_ERR_CAPTURE_EN (first-error capture ports).
//
// Handshake: a request is taken in IDLE when m_cyc_i & m_stb_i are high;
// the transfer completes in the cycle m_ack_o or m_err_o is high, and the
// following cycle is always IDLE, so the master has one cycle to drop stb.
module wb_decode_interconnect
  import wb_ic_pkg::*;
#(
  parameter int NUM_SLAVES     = NUM_SLAVES_DEF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [31:0]              m_adr_i,
  input  logic [31:0]              m_dat_i,
  input  logic [3:0]               m_sel_i,
  input  logic                     m_we_i,
  input  logic                     m_cyc_i,
  input  logic                     m_stb_i,
  output logic [31:0]              m_dat_o,
  output logic                     m_ack_o,
  output logic                     m_err_o,
  output logic [31:0]              s_adr_o,
  output logic [31:0]              s_dat_o,
  output logic [3:0]               s_sel_o,
  output logic                     s_we_o,
  output logic [NUM_SLAVES-1:0]    s_cyc_o,
  output logic [NUM_SLAVES-1:0]    s_stb_o,
  input  logic [32*NUM_SLAVES-1:0] s_dat_i,
  input  logic [NUM_SLAVES-1:0]    s_ack_i,
  input  logic [NUM_SLAVES-1:0]    s_err_i,
`ifdef WB_IC_ERR_CAPTURE_EN
  output logic [31:0]              err_addr_o,
  output logic [1:0]               err_cause_o,
  output logic                     err_valid_o,
  input  logic                     err_clr_i,
`endif
  output wb_ic_state_t             dbg_state_o
);

  localparam int IDX_W = idx_w(NUM_SLAVES);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  wb_ic_state_t     state_q, state_d;
  logic [31:0]      adr_q, dat_q;
  logic [3:0]       sel_q;
  logic             we_q;
  logic [IDX_W-1:0] idx_q;
  logic [15:0]      cnt_q, cnt_d;
  logic [31:0]      rdat_q;

  logic             dec_hit;
  logic [IDX_W-1:0] dec_idx;
  logic             latch_req;
  logic             capture_rd;
  logic             timeout_hit;
  logic [NUM_SLAVES-1:0] slv_oh;
  logic             sel_ack, sel_err;
  logic [31:0]      sel_dat;
  err_cause_t       err_now;

  wb_ic_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .IDX_W      (IDX_W)
  ) u_dec (
    .adr_i (m_adr_i),
    .hit_o (dec_hit),
    .idx_o (dec_idx)
  );

  assign slv_oh      = NUM_SLAVES'(1) << idx_q;
  assign sel_ack     = |(s_ack_i & slv_oh);
  assign sel_err     = |(s_err_i & slv_oh);
  assign timeout_hit = (cnt_q == TO_LAST);

  // Read data mux for the latched slave index.
  always_comb begin
    sel_dat = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (idx_q == IDX_W'(k)) sel_dat = s_dat_i[k*32 +: 32];
    end
  end

  // Next-state, master response and slave select decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    latch_req  = 1'b0;
    capture_rd = 1'b0;
    m_ack_o    = 1'b0;
    m_err_o    = 1'b0;
    s_cyc_o    = '0;
    err_now    = ERR_NONE;
    case (state_q)
      IDLE: begin
        if (m_cyc_i && m_stb_i) begin
          latch_req = 1'b1;
          cnt_d     = '0;
          state_d   = dec_hit ? ACTIVE : ERR;
        end
      end
      ACTIVE: begin
        // The slave is released immediately on master abort or timeout.
        if (m_cyc_i && !timeout_hit) s_cyc_o = slv_oh;
        if (!m_cyc_i) begin
          state_d = IDLE;
        end else if (sel_err) begin
          m_err_o = 1'b1;
          err_now = ERR_SLAVE;
          state_d = IDLE;
        end else if (sel_ack) begin
          m_ack_o    = 1'b1;
          capture_rd = !we_q;
          state_d    = IDLE;
        end else if (timeout_hit) begin
          m_err_o = 1'b1;
          err_now = ERR_TIMEOUT;
          state_d = IDLE;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ERR: begin
        m_err_o = 1'b1;
        err_now = ERR_UNMAPPED;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign s_stb_o     = s_cyc_o;
  assign s_adr_o     = adr_q;
  assign s_dat_o     = dat_q;
  assign s_sel_o     = sel_q;
  assign s_we_o      = we_q;
  assign m_dat_o     = rdat_q;
  assign dbg_state_o = state_q;

  // State, timeout counter and request latch registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_req) begin
        adr_q <= m_adr_i;
        dat_q <= m_dat_i;
        sel_q <= m_sel_i;
        we_q  <= m_we_i;
        idx_q <= dec_idx;
      end
    end
  end

  // Read data is registered on a successful read ack and held otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdat_q <= '0;
    else if (capture_rd) rdat_q <= sel_dat;
  end

`ifdef WB_IC_ERR_CAPTURE_EN
  // First-error capture; a clear wins over a new error in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_valid_o <= 1'b0;
      err_addr_o  <= '0;
      err_cause_o <= '0;
    end else if (err_clr_i) begin
      err_valid_o <= 1'b0;
    end else if (!err_valid_o && (err_now != ERR_NONE)) begin
      err_valid_o <= 1'b1;
      err_addr_o  <= adr_q;
      err_cause_o <= err_now;
    end
  end
`else
  logic unused_err_now;
  assign unused_err_now = ^err_now;
`endif

endmodule

// File: tb/tb_wb_decode_interconnect.sv
// Self-checking bench for wb_decode_interconnect: a table of transfers
// run through a generic driver/slave-responder task, a few random
// transfers, and hand-written abort and async-reset sequences.
module tb_wb_decode_interconnect;
  import wb_ic_pkg::*;

  localparam int NS = 4;
  localparam int TO = 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [31:0]      m_adr_i = '0, m_dat_i = '0;
  logic [3:0]       m_sel_i = '0;
  logic             m_we_i = 1'b0, m_cyc_i = 1'b0, m_stb_i = 1'b0;
  logic [31:0]      m_dat_o;
  logic             m_ack_o, m_err_o;
  logic [31:0]      s_adr_o, s_dat_o;
  logic [3:0]       s_sel_o;
  logic             s_we_o;
  logic [NS-1:0]    s_cyc_o, s_stb_o;
  logic [32*NS-1:0] s_dat_i = '0;
  logic [NS-1:0]    s_ack_i = '0, s_err_i = '0;
  wb_ic_state_t     dbg_state_o;
`ifdef WB_IC_ERR_CAPTURE_EN
  logic [31:0]      err_addr_o;
  logic [1:0]       err_cause_o;
  logic             err_valid_o;
  logic             err_clr_i = 1'b0;
`endif

  wb_decode_interconnect #(.NUM_SLAVES(NS), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
`ifdef WB_IC_ERR_CAPTURE_EN
    .err_addr_o(err_addr_o), .err_cause_o(err_cause_o),
    .err_valid_o(err_valid_o), .err_clr_i(err_clr_i),
`endif
    .dbg_state_o(dbg_state_o)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard state.
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // resp: 0 ack, 1 err, 2 ack+err, 3 silent. exp_cyc == 0 means unmapped.
  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] wdat;
    logic [3:0]  sel;
    int          resp;
    int          wt;
    logic [31:0] rdat;
    logic [3:0]  exp_cyc;
  } txn_t;

  function automatic int oh2idx(input logic [3:0] oh);
    oh2idx = 0;
    for (int k = 0; k < NS; k++) if (oh[k]) oh2idx = k;
  endfunction

  // Drives one master transfer, plays the addressed slave, and checks the
  // routing, response timing, response kind, bubble cycle and read data.
  task automatic run_txn(input txn_t t);
    int   sidx, n, done_at, exp_at;
    bit   done, exp_ack;
    logic ack_s, err_s;
    logic [3:0] cyc_s;
    logic [1:0] exp_cause;
    sidx    = oh2idx(t.exp_cyc);
    exp_ack = (t.exp_cyc != 0) && (t.resp == 0);
    if (!t.we && exp_ack) last_rd = t.rdat;
    exp_q.push_back(last_rd);
    exp_at  = (t.exp_cyc == 0) ? 1 : (t.resp == 3) ? TO : 1 + t.wt;
    for (int k = 0; k < NS; k++)
      s_dat_i[k*32 +: 32] = (k == sidx) ? t.rdat : (32'hBAD0_0000 | 32'(k));
    m_adr_i = t.adr; m_we_i = t.we; m_dat_i = t.wdat; m_sel_i = t.sel;
    m_cyc_i = 1'b1; m_stb_i = 1'b1;
    done = 0; done_at = 0; n = 0; ack_s = 0; err_s = 0; cyc_s = '0;
    while (!done && n < 64) begin
      @(negedge clk);
      if (n >= 1 && t.exp_cyc != 0 && t.resp != 3 && (n - 1) == t.wt) begin
        s_ack_i[sidx] = (t.resp == 0 || t.resp == 2);
        s_err_i[sidx] = (t.resp == 1 || t.resp == 2);
      end
      #1;
      if (n == 1) begin
        chk("s_cyc", 32'(s_cyc_o), 32'(t.exp_cyc));
        chk("s_stb", 32'(s_stb_o), 32'(s_cyc_o));
        chk("s_adr", s_adr_o, t.adr);
        chk("s_we", 32'(s_we_o), 32'(t.we));
        chk("s_sel", 32'(s_sel_o), 32'(t.sel));
        if (t.we) chk("s_dat", s_dat_o, t.wdat);
      end
      if (m_ack_o || m_err_o) begin
        done = 1; done_at = n; ack_s = m_ack_o; err_s = m_err_o; cyc_s = s_cyc_o;
      end
      @(posedge clk); #1;
      s_ack_i = '0; s_err_i = '0;
      if (done) begin m_cyc_i = 1'b0; m_stb_i = 1'b0; end
      n++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL response: no ack/err within 64 cycles for adr %h", t.adr);
      m_cyc_i = 1'b0; m_stb_i = 1'b0;
      @(posedge clk); #1;
    end
    chk("latency", 32'(done_at), 32'(exp_at));
    chk("m_ack", 32'(ack_s), 32'(exp_ack));
    chk("m_err", 32'(err_s), 32'(!exp_ack));
    if (t.resp == 3 && t.exp_cyc != 0) chk("timeout_cyc_drop", 32'(cyc_s), 32'h0);
    chk("m_dat", m_dat_o, exp_q.pop_front());
    chk("bubble_resp", {30'h0, m_ack_o, m_err_o}, 32'h0);
    chk("bubble_cyc", 32'(s_cyc_o), 32'h0);
    chk("bubble_state", 32'(dbg_state_o), 32'(IDLE));
`ifdef WB_IC_ERR_CAPTURE_EN
    if (!exp_ack) begin
      exp_cause = (t.exp_cyc == 0) ? 2'b01 : (t.resp == 3) ? 2'b11 : 2'b10;
      chk("cap_valid", 32'(err_valid_o), 32'h1);
      chk("cap_cause", 32'(err_cause_o), 32'(exp_cause));
      chk("cap_addr", err_addr_o, t.adr);
      err_clr_i = 1'b1;
      @(posedge clk); #1;
      err_clr_i = 1'b0;
      chk("cap_clear", 32'(err_valid_o), 32'h0);
    end
`endif
  endtask

  txn_t tbl[10];
  txn_t r;

  initial begin
    tbl[0] = '{32'h2000_1004, 1'b0, 32'h0,         4'hF, 0, 1, 32'hDEAD_BEEF, 4'b0100};
    tbl[1] = '{32'h0000_0010, 1'b1, 32'h1234_5678, 4'hF, 0, 3, 32'h5555_0000, 4'b0001};
    tbl[2] = '{32'h3000_0000, 1'b0, 32'h0,         4'hF, 0, 0, 32'h0,         4'b0000};
    tbl[3] = '{32'h2000_0000, 1'b0, 32'h0,         4'hF, 3, 0, 32'h0,         4'b0010};
    tbl[4] = '{32'h2000_2008, 1'b0, 32'h0,         4'hF, 2, 0, 32'h7777_7777, 4'b1000};
    tbl[5] = '{32'h0FFF_FFFC, 1'b0, 32'h0,         4'h3, 0, 0, 32'hA5A5_0001, 4'b0001};
    tbl[6] = '{32'h2000_2FFC, 1'b0, 32'h0,         4'hF, 1, 2, 32'h6666_6666, 4'b1000};
    tbl[7] = '{32'h2000_3000, 1'b0, 32'h0,         4'hF, 0, 0, 32'h0,         4'b0000};
    tbl[8] = '{32'h2000_0FF0, 1'b1, 32'hCAFE_F00D, 4'hC, 0, 0, 32'h4444_4444, 4'b0010};
    tbl[9] = '{32'h1000_0000, 1'b0, 32'h0,         4'hF, 0, 0, 32'h0,         4'b0000};

    // Reset state.
    #2;
    chk("rst_m_dat", m_dat_o, 32'h0);
    chk("rst_m_resp", {30'h0, m_ack_o, m_err_o}, 32'h0);
    chk("rst_s_bus", s_adr_o | s_dat_o | 32'(s_sel_o) | 32'(s_we_o), 32'h0);
    chk("rst_s_cyc", 32'({s_cyc_o, s_stb_o}), 32'h0);
    chk("rst_state", 32'(dbg_state_o), 32'(IDLE));
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) run_txn(tbl[i]);

    // Random mapped transfers with random wait states.
    for (int i = 0; i < 6; i++) begin
      int k;
      k = $urandom_range(0, NS - 1);
      r.adr = (k == 0) ? ($urandom_range(0, 32'h0FFF_FFFF) & 32'hFFFF_FFFC)
                       : (slave_base(k) | ($urandom_range(0, 32'hFFF) & 32'hFFC));
      r.we = 1'($urandom_range(0, 1));
      r.wdat = $urandom; r.sel = 4'($urandom_range(1, 15));
      r.resp = 0; r.wt = $urandom_range(0, 3); r.rdat = $urandom;
      r.exp_cyc = 4'(1 << k);
      run_txn(r);
    end

    // Master abort while a slave is stalling.
    exp_q.push_back(last_rd);
    m_adr_i = 32'h2000_0000; m_we_i = 1'b0; m_sel_i = 4'hF;
    m_cyc_i = 1'b1; m_stb_i = 1'b1;
    @(posedge clk); #1;
    chk("abort_cyc_before", 32'(s_cyc_o), 32'b0010);
    @(posedge clk);
    @(negedge clk);
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    #1;
    chk("abort_cyc_same", 32'(s_cyc_o), 32'h0);
    chk("abort_resp", {30'h0, m_ack_o, m_err_o}, 32'h0);
    @(posedge clk); #1;
    chk("abort_state", 32'(dbg_state_o), 32'(IDLE));
    chk("abort_m_dat", m_dat_o, exp_q.pop_front());
    @(posedge clk); #1;
    chk("abort_idle_resp", {30'h0, m_ack_o, m_err_o}, 32'h0);

    // Asynchronous reset during ACTIVE.
    m_adr_i = 32'h2000_1000; m_cyc_i = 1'b1; m_stb_i = 1'b1;
    @(posedge clk); #1;
    chk("rstact_cyc_before", 32'(s_cyc_o), 32'b0100);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rstact_cyc", 32'({s_cyc_o, s_stb_o}), 32'h0);
    chk("rstact_bus", s_adr_o, 32'h0);
    chk("rstact_m_dat", m_dat_o, 32'h0);
    chk("rstact_state", 32'(dbg_state_o), 32'(IDLE));
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    last_rd = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rstrel_state", 32'(dbg_state_o), 32'(IDLE));
    chk("rstrel_cyc", 32'(s_cyc_o), 32'h0);

    // One more read after reset release to show the bus recovers.
    run_txn(tbl[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_decode_interconnect.md
Name: wb_decode_interconnect

Overview:
- Wishbone single-master, multi-slave interconnect sitting directly downstream of the core/debug Wishbone controller.
- Decodes the master address against a fixed slave map and drives cyc/stb to exactly one slave.
- Returns ack/err to the master and registers read data one cycle after ack, so the controller's delayed load-alignment path sees valid data.
- Generates a bus error for unmapped addresses and for slaves that fail to respond within a timeout window.

Parameters:
- NUM_SLAVES, 4, number of slave ports; the map comes from package constants indexed 0..NUM_SLAVES-1.
- TIMEOUT_CYCLES, 255, cycles in ACTIVE without slave ack/err before a timeout error is forced; legal range 1..65535.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- m_adr_i  in  32  master address
- m_dat_i  in  32  master write data
- m_sel_i  in  4  master byte enables
- m_we_i  in  1  master write enable
- m_cyc_i  in  1  master cycle
- m_stb_i  in  1  master strobe
- m_dat_o  out  32  registered read data to master
- m_ack_o  out  1  acknowledge to master
- m_err_o  out  1  error to master
- s_adr_o  out  32  shared slave address (latched)
- s_dat_o  out  32  shared slave write data (latched)
- s_sel_o  out  4  shared byte enables (latched)
- s_we_o  out  1  shared write enable (latched)
- s_cyc_o  out  NUM_SLAVES  per-slave cycle, one-hot or zero
- s_stb_o  out  NUM_SLAVES  per-slave strobe, equal to s_cyc_o
- s_dat_i  in  32*NUM_SLAVES  slave read data; slave k occupies bits [32k+31:32k]
- s_ack_i  in  NUM_SLAVES  slave acks
- s_err_i  in  NUM_SLAVES  slave errors

Behaviour:
- Reset (async, reset_n=0): state=IDLE; all outputs 0; timeout counter 0; latched select 0.
- State IDLE:
  - On m_cyc_i&m_stb_i, latch adr/dat/sel/we and the decoded slave index.
  - Hit: go to ACTIVE; s_cyc_o/s_stb_o[idx]=1 from the next cycle.
  - Miss (no match): go to ERR.
- State ACTIVE:
  - m_ack_o = s_ack_i[idx] and m_err_o = s_err_i[idx], combinational pass-through.
  - On ack: capture s_dat_i[idx] into m_dat_o (visible next cycle), drop s_cyc/s_stb, go to IDLE.
  - On err: same as ack, but m_dat_o is not updated.
  - Ack and err in the same cycle: err wins; m_ack_o=0, m_err_o=1.
  - The timeout counter increments each ACTIVE cycle. When it equals TIMEOUT_CYCLES-1 with no ack/err: m_err_o=1 for that cycle, slave dropped, go to IDLE.
  - If m_cyc_i falls while ACTIVE (master abort, e.g. halt switch): drop the slave the same cycle, go to IDLE, no ack or err.
- State ERR: m_err_o=1 for exactly one cycle, no slave touched, then IDLE.
- Decode: slave k matches when (adr & MASK[k]) == BASE[k]. On multiple matches, the lowest index wins.
- Minimum latency is request to ack = 2 cycles (latch + slave zero-wait ack). The cycle after any ack/err is always IDLE (one bubble), which guarantees no double issue while the master deasserts its stall.
- m_dat_o holds its value until the next successful read ack; writes leave it unchanged.
- Timeout counter clears on entry to ACTIVE and saturates; it never wraps.

Optional Feature:
- Macro: WB_IC_ERR_CAPTURE_EN.
- Defined: adds ports err_addr_o (out, 32), err_cause_o (out, 2; 01=unmapped, 10=slave err, 11=timeout), err_valid_o (out, 1) and err_clr_i (in, 1).
  - On the first error, record the latched address and cause and set err_valid_o.
  - Later errors are ignored while err_valid_o=1.
  - err_clr_i clears err_valid_o the next cycle; clear has priority over a simultaneous new error.
  - All three outputs reset to 0.
- Undefined: these ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Package wb_ic_pkg:
  - NUM_SLAVES_DEF.
  - SLAVE_BASE and SLAVE_MASK arrays (default map: 0x0000_0000/0xF000_0000 memory, 0x2000_0000/0xFFFF_F000, 0x2000_1000/0xFFFF_F000, 0x2000_2000/0xFFFF_F000).
  - State enum wb_ic_state_t {IDLE, ACTIVE, ERR}.
  - err_cause_t.
- Sub-module wb_ic_addr_decoder: combinational; inputs adr; outputs hit and idx (clog2(NUM_SLAVES) bits).

Test Plan:
- Read 0x2000_1004; slave2 acks 1 cycle after its stb with 0xDEADBEEF -> s_cyc_o=0100, m_ack_o one cycle, m_dat_o=0xDEADBEEF the following cycle.
- Write 0x0000_0010, data 0x12345678, sel 1111; slave0 acks after 3 wait states -> s_we_o=1, s_dat_o=0x12345678, single m_ack_o, m_dat_o unchanged.
- Read 0x3000_0000 (unmapped) -> no s_cyc_o asserted, m_err_o=1 for exactly one cycle, return to IDLE.
- Slave1 never acks, TIMEOUT_CYCLES=8 -> m_err_o=1 on the 8th ACTIVE cycle, s_cyc_o drops the same cycle; with the macro enabled, err_cause_o=11 and err_addr_o=0x2000_0000.
- Slave3 asserts ack and err together -> m_err_o=1, m_ack_o=0; m_cyc_i dropped mid-ACTIVE -> slave released, no ack/err.
- reset_n pulsed low during ACTIVE -> all outputs 0 immediately (async), state IDLE after release.
